// File: rtl/fft_pkg.sv
// Shared types and helpers for the SDF FFT pipeline.
// Bit reversal and the packed complex sample live here.
package fft_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int N_DEF          = 16;
  localparam int LOG2_N_DEF     = $clog2(N_DEF);

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] re;
    logic [DATA_WIDTH_DEF-1:0] im;
  } cplx_t;

  function automatic logic [31:0] bitrev(
    input logic [31:0] x,
    input int          bits
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < bits; i++)
      r[i] = x[bits-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store, one write and one read port.
// Read is asynchronous; the caller registers the output.
module fft_pingpong_ram #(
  parameter int W  = 32,
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [2*N];

  always_ff @(posedge clk) begin
    if (we)
      mem[{wr_bank, wr_addr}] <= wr_data;
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural order.
// Ping-pong banks sustain 1 sample/cycle with valid/ready flow control.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_last
);

  localparam int AW = $clog2(N);
  localparam int W  = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  generate
    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("fft_bitrev_reorder: N must be a power of 2 and >= 4");
    end
  endgenerate

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  rd_data;
  logic          wr_en;
  logic          ld;

  assign in_ready = !full[wr_bank];
  assign wr_en    = in_valid && in_ready;
  assign ld       = full[rd_bank] && (!out_valid || out_ready);
  assign wr_addr  = AW'(bitrev(32'(wr_cnt), AW));

  fft_pingpong_ram #(
    .W  (W),
    .N  (N),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data ({in_re, in_im}),
    .rd_bank (rd_bank),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  // Writer set and reader clear always hit different banks.
  always_comb begin
    full_nxt = full;
    if (wr_en && wr_cnt == LAST)
      full_nxt[wr_bank] = 1'b1;
    if (ld && rd_cnt == LAST)
      full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        wr_cnt <= wr_cnt + AW'(1);
        if (wr_cnt == LAST)
          wr_bank <= !wr_bank;
      end
      if (ld) begin
        out_re    <= rd_data[W-1 -: DATA_WIDTH];
        out_im    <= rd_data[DATA_WIDTH-1:0];
        out_valid <= 1'b1;
        out_last  <= (rd_cnt == LAST);
        rd_cnt    <= rd_cnt + AW'(1);
        if (rd_cnt == LAST)
          rd_bank <= !rd_bank;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer for the SDF FFT pipeline. It consumes one complex sample per cycle in the bit-reversed order produced by the last butterfly stage, and emits each N-point frame in natural order. It sits between the final butterfly/twiddle stage and downstream consumers. Ping-pong banks give sustained 1 sample/cycle throughput, and valid/ready handshakes allow back-pressure.

## Interface
- DATA_WIDTH, 16, bit width of each real/imag component
- N, 16, FFT frame length; power of 2, N >= 4
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_re  input  DATA_WIDTH  real part, bit-reversed frame order
- in_im  input  DATA_WIDTH  imaginary part
- out_valid  output  1  out_re/out_im hold a valid sample
- out_ready  input  1  downstream accepts the sample
- out_re  output  DATA_WIDTH  real part, natural order
- out_im  output  DATA_WIDTH  imaginary part
- out_last  output  1  high with the final (index N-1) sample of a frame

## Operation
- Storage: 2 banks × N entries × 2·DATA_WIDTH bits. Memory contents are not reset.
- State: wr_bank, rd_bank (1 bit each); full[1:0]; wr_cnt, rd_cnt (log2(N) bits each).
- in_ready = !full[wr_bank]. A write occurs when in_valid && in_ready.
- Write path:
  - Sample goes to bank wr_bank at address bitrev(wr_cnt).
  - wr_cnt increments.
  - On wr_cnt == N-1: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Read path (load):
  - Load condition: full[rd_bank] && (!out_valid || out_ready).
  - On load: register bank rd_bank[rd_cnt] into out_re/out_im, set out_valid = 1, set out_last = (rd_cnt == N-1), increment rd_cnt.
  - On rd_cnt == N-1: clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
- If out_valid && out_ready and no load occurs, out_valid goes to 0.
- Output is held stable while out_valid && !out_ready.
- Simultaneous set (writer) and clear (reader) always target different banks; both must take effect in the same cycle.
- A bank is never written while full. A bank cleared in cycle t is writable in cycle t+1, not in t.
- Reset, including mid-frame: full = 0, banks 0, counters 0, out_valid/out_last/out_re/out_im = 0. Partial frames are discarded with no output.
- bitrev(x): reverse the log2(N) LSBs of x.
- Data passes through unmodified; no arithmetic.

## Timing
- Read is combinational from the array into the registered output, giving 1 register of output latency.
- With continuous in_valid from cycle 0 and out_ready = 1:
  - full set at the end of cycle N-1.
  - First out_valid in cycle N+1, as natural index 0.
  - out_last in cycle 2N.
- Sustained throughput: 1 sample/cycle with both sides streaming; in_ready stays 1.
- Back-pressure:
  - With out_ready = 0, the second frame fills the other bank.
  - in_ready drops the cycle after the second frame completes.
  - in_ready returns 1 the cycle after the reader clears the first bank.
- Minimum gap between frames on input: 0 cycles.

## Structure
- Shared package fft_pkg holds:
  - Function bitrev(x, bits).
  - Typedef cplx_t (packed struct re/im, DATA_WIDTH-parameterised via package localparam default).
  - Localparam for log2(N) derivation.
- Sub-module fft_pingpong_ram: 2-bank, 1 write and 1 read port, registered nothing. Top holds counters, flags and the output register.
- Elaboration check: N power of 2 and N >= 4.

## Test plan
- N=8, reset, stream in_re = j, in_im = 100+j for j = 0..7 with out_ready = 1 -> out_re = 0,4,2,6,1,5,3,7 and out_im = 100 + same, starting cycle 9; out_last only on the 8th sample.
- 3 back-to-back frames (offsets 0/8/16), out_ready = 1 -> in_ready never drops; 24 outputs contiguous, each frame permuted as above.
- out_ready = 0 during 2 full frames -> in_ready = 0 after the 16th write. Raise out_ready -> out_valid held with sample 0 until accepted; in_ready returns after 8 reads.
- Random out_ready toggling (50%) over 10 frames -> no sample lost or duplicated; data stable while stalled.
- Assert rst low after 5 writes of a frame, release, then send a full frame -> no output from the partial frame; the new frame is correct; all outputs 0 during reset.
- in_valid gaps (every other cycle) -> output order and out_last position unchanged.
